// File: rtl/fft_bitrev_ctrl_pkg.sv
// fft_bitrev_ctrl_pkg: controller state encoding and the shared index bit-reversal helper.
package fft_bitrev_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, CHK, RD_A, RD_B, WR_A, WR_B, DONE} state_t;

    localparam int REV_MAXW = 32;

    // Reverses the low n bits of x; bits at and above n come back as zero.
    function automatic logic [REV_MAXW-1:0] bitrev(input logic [REV_MAXW-1:0] x, input int n);
        logic [REV_MAXW-1:0] v, r;
        v = x;
        r = '0;
        for (int k = 0; k < REV_MAXW; k++)
            if (k < n) begin
                r = {r[REV_MAXW-2:0], v[0]};
                v = v >> 1;
            end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_ctrl_bit_rev.sv
// fft_bitrev_ctrl_bit_rev: combinational FFTSIZ-bit index reversal.
module fft_bitrev_ctrl_bit_rev
    import fft_bitrev_ctrl_pkg::*;
#(
    parameter int FFTSIZ = 3
) (
    input  logic [FFTSIZ-1:0] i,
    output logic [FFTSIZ-1:0] r
);

    assign r = FFTSIZ'(bitrev(REV_MAXW'(i), FFTSIZ));

endmodule

// File: rtl/fft_bitrev_ctrl.sv
// fft_bitrev_ctrl: in-place bit-reversal reorder of a 2^FFTSIZ block through one req/gnt memory port.
module fft_bitrev_ctrl
    import fft_bitrev_ctrl_pkg::*;
#(
    parameter int MDATAW = 8,
    parameter int NUBITS = 16,
    parameter int FFTSIZ = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MDATAW-1:0] base,
    output logic              busy,
    output logic              done,
    output logic              req,
    input  logic              gnt,
    output logic [MDATAW-1:0] mem_addr,
    output logic              mem_we,
    output logic [NUBITS-1:0] mem_wdata,
    input  logic [NUBITS-1:0] mem_rdata
);

    localparam logic [FFTSIZ-1:0] LAST = '1;

    state_t            state, nxt;
    logic [FFTSIZ-1:0] i, nxt_i, ri;
    logic [MDATAW-1:0] base_r;
    logic [NUBITS-1:0] reg_a, reg_b;
    logic              cap_a, cap_b;

    fft_bitrev_ctrl_bit_rev #(.FFTSIZ(FFTSIZ)) u_bit_rev (.i(i), .r(ri));

    always_comb begin
        nxt   = state;
        nxt_i = i;
        case (state)
            IDLE: if (start) begin
                nxt   = CHK;
                nxt_i = '0;
            end
            CHK: begin
                nxt   = (i < ri) ? RD_A : (i == LAST) ? DONE : CHK;
                nxt_i = (i < ri || i == LAST) ? i : i + 1'b1;
            end
            RD_A: nxt = gnt ? RD_B : RD_A;
            RD_B: nxt = gnt ? WR_A : RD_B;
            WR_A: nxt = gnt ? WR_B : WR_A;
            WR_B: if (gnt) begin
                nxt   = (i == LAST) ? DONE : CHK;
                nxt_i = (i == LAST) ? i : i + 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            i        <= '0;
            base_r   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            req      <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            cap_a    <= 1'b0;
            cap_b    <= 1'b0;
        end else begin
            state    <= nxt;
            i        <= nxt_i;
            base_r   <= (state == IDLE && start) ? base : base_r;
            busy     <= nxt inside {CHK, RD_A, RD_B, WR_A, WR_B};
            done     <= nxt == DONE;
            req      <= nxt inside {RD_A, RD_B, WR_A, WR_B};
            mem_we   <= nxt inside {WR_A, WR_B};
            mem_addr <= (nxt inside {RD_A, WR_A}) ? base_r + MDATAW'(i) :
                        (nxt inside {RD_B, WR_B}) ? base_r + MDATAW'(ri) : '0;
            cap_a    <= state == RD_A && gnt;
            cap_b    <= state == RD_B && gnt;
            reg_a    <= cap_a ? mem_rdata : reg_a;
            reg_b    <= cap_b ? mem_rdata : reg_b;
        end
    end

    // The partner word is still on mem_rdata during the first WR_A cycle; forward it until reg_b holds it.
    assign mem_wdata = (state == WR_A) ? (cap_b ? mem_rdata : reg_b) :
                       (state == WR_B) ? reg_a : '0;

endmodule

// File: doc/fft_bitrev_ctrl.md
# fft_bitrev_ctrl

In-place bit-reversal reorder controller for FFT buffers held in processor data memory. On a start pulse it walks every index of a 2^FFTSIZ-entry block at a programmable base address and swaps each element with its bit-reversed partner. It uses a single shared memory port arbitrated by a req/gnt handshake. The block sits beside the indexed/bit-reversed address path as its sequencer, so software can bulk-reorder a buffer instead of issuing per-element reversed accesses.

## Interface
- MDATAW, 8: data-memory address width
- NUBITS, 16: data word width
- FFTSIZ, 3: log2 of FFT block length N; must satisfy 1 ≤ FFTSIZ ≤ MDATAW

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin reorder; honoured only in IDLE
- base  in  MDATAW  block base address; latched when start is accepted
- busy  out  1  high while the reorder is in progress
- done  out  1  one-cycle completion pulse
- req  out  1  memory access request
- gnt  in  1  grant; an access completes on any cycle with req & gnt
- mem_addr  out  MDATAW  access address
- mem_we  out  1  write enable, qualified by req
- mem_wdata  out  NUBITS  write data
- mem_rdata  in  NUBITS  read data, valid the cycle after a granted read

## Operation
- States: IDLE, CHK, RD_A, RD_B, WR_A, WR_B, DONE.
- IDLE, start=1: latch base, clear index i, go to CHK.
- CHK (no memory access):
  - if i < rev(i), go to RD_A;
  - else if i == N-1, go to DONE;
  - else increment i and stay in CHK.
- rev(i) is the FFTSIZ-bit bit reversal: bit k maps to bit FFTSIZ-1-k.
- RD_A: req=1, we=0, addr=base+i. On gnt, go to RD_B.
- RD_B: req=1, we=0, addr=base+rev(i). On gnt, go to WR_A.
- WR_A: req=1, we=1, addr=base+i, wdata=reg_b. On gnt, go to WR_B.
- WR_B: req=1, we=1, addr=base+rev(i), wdata=reg_a. On gnt:
  - if i == N-1, go to DONE;
  - else increment i and go to CHK.
- Read-data capture:
  - reg_a captures mem_rdata exactly once, on the cycle after the RD_A grant.
  - reg_b captures mem_rdata exactly once, on the cycle after the RD_B grant.
  - A registered capture flag makes this independent of later gnt stalls.
- Address arithmetic: base + index, zero-extended, truncated to MDATAW bits, so addresses wrap modulo 2^MDATAW.
- DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored, including in the DONE cycle.
- A pair is swapped only from its lower index, so each pair is swapped exactly once. Palindromic indices (i == rev(i)) cause no access.

## Timing
- Reset values (asynchronous, rst=0): state IDLE, i=0, busy=0, done=0, req=0, mem_we=0, mem_addr=0, mem_wdata=0, reg_a=reg_b=0.
- Reset mid-operation aborts immediately; a partially swapped pair is left as-is.
- All outputs are registered or decoded from state only; no combinational path from gnt or start to outputs.
- busy=1 in CHK through WR_B, and 0 in IDLE and DONE.
- req is held with stable addr/we/wdata until granted. With gnt=0, the state and outputs freeze.
- With gnt=1 held, latency from the start edge is N CHK cycles + 4 cycles per swapped pair, then one DONE cycle.
- Example, FFTSIZ=3: pairs (1,4) and (3,6) are swapped; busy lasts 16 cycles; done is high in cycle 17 after start.
- FFTSIZ=1: no pairs; CHK runs 2 cycles, then DONE.

## Structure
- Shared package: state enum/localparams, and the reversal function reused by the indexed-address path.
- One natural sub-module, bit_rev: combinational, parameter FFTSIZ, in i, out rev(i).
- Controller FSM, index counter and data registers live in fft_bitrev_ctrl.

## Test plan
- Reset, FFTSIZ=3, gnt=1, base=0x10, memory word k = k: start → busy 16 cycles, done in cycle 17; memory 0x10..0x17 = 0,4,2,6,1,5,3,7.
- Random gnt (50% low) on the same setup → identical final memory. Each request's addr/we/wdata is held stable until granted; exactly 8 granted accesses.
- base=0xFC, FFTSIZ=3 → accesses wrap to 0x00..0x03. Block 0xFC..0x03 is reordered; 0x04 is untouched.
- start pulsed while busy and in the DONE cycle → ignored; exactly one done pulse.
- rst asserted during WR_A → outputs zero asynchronously, state IDLE. A new start then runs normally to done.
- FFTSIZ=1 → no req ever asserted; done 3 cycles after start.
